// File: rtl/led_scan_pkg.sv
// Shared constants and helpers for the LED scan driver.
// Optional brightness dimming is enabled with LED_SCAN_DIM_EN.
package led_scan_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int SEG_W      = 8;

    typedef logic [SEG_W-1:0] seg_vec_t;

    function automatic seg_vec_t off_pattern(input bit active_low);
        return active_low ? '1 : '0;
    endfunction

endpackage

// File: rtl/led_scan_timer.sv
// Slot/digit counters for the LED scan driver.
// Produces the current digit, blank window, snapshot strobe and frame end.
module led_scan_timer #(
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    output logic [2:0] idx,
    output logic       in_blank,
    output logic       snap_stb,
    output logic       frame_end
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;
    logic          wrap;

    assign wrap = (cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n || !enable) begin
            cnt <= '0;
            idx <= 3'd0;
        end else if (wrap) begin
            cnt <= '0;
            idx <= idx + 3'd1;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // A zero-length gap would compare an unsigned count against zero
    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign in_blank = 1'b0;
        end else begin : g_blank
            assign in_blank = (cnt < CW'(BLANK_CYCLES));
        end
    endgenerate

    assign snap_stb  = (idx == 3'd0) && (cnt == '0);
    assign frame_end = (idx == 3'd7) && wrap;

endmodule

// File: rtl/led_scan_driver.sv
// Time-multiplexed 8-digit seven-segment scan driver with frame snapshot.
// Define LED_SCAN_DIM_EN to add the frame-PWM brightness control.
module led_scan_driver
    import led_scan_pkg::*;
#(
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 1000,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [7:0] seg0_i,
    input  logic [7:0] seg1_i,
    input  logic [7:0] seg2_i,
    input  logic [7:0] seg3_i,
    input  logic [7:0] seg4_i,
    input  logic [7:0] seg5_i,
    input  logic [7:0] seg6_i,
    input  logic [7:0] seg7_i,
`ifdef LED_SCAN_DIM_EN
    input  logic [2:0] bright,
`endif
    output logic [7:0] seg_o,
    output logic [7:0] an_o,
    output logic       frame_o
);

    localparam seg_vec_t OFF = off_pattern(ACTIVE_LOW != 0);

    logic [2:0] idx;
    logic       in_blank;
    logic       snap_stb;
    logic       frame_end;
    logic       lit;
    seg_vec_t   seg_in [NUM_DIGITS];
    seg_vec_t   snap   [NUM_DIGITS];
    seg_vec_t   seg_nxt;
    seg_vec_t   an_nxt;

    led_scan_timer #(
        .CLK_DIV      (CLK_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .idx       (idx),
        .in_blank  (in_blank),
        .snap_stb  (snap_stb),
        .frame_end (frame_end)
    );

    assign seg_in[0] = seg0_i;
    assign seg_in[1] = seg1_i;
    assign seg_in[2] = seg2_i;
    assign seg_in[3] = seg3_i;
    assign seg_in[4] = seg4_i;
    assign seg_in[5] = seg5_i;
    assign seg_in[6] = seg6_i;
    assign seg_in[7] = seg7_i;

    // Whole-frame snapshot so a digit never tears mid-scan
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                snap[i] <= '0;
            end
        end else if (enable && snap_stb) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                snap[i] <= seg_in[i];
            end
        end
    end

`ifdef LED_SCAN_DIM_EN
    logic [2:0] pwm;
    logic [2:0] bright_snap;
    logic       pwm_on;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwm         <= 3'd0;
            bright_snap <= 3'd0;
        end else if (!enable) begin
            pwm <= 3'd0;
        end else begin
            if (frame_end) begin
                pwm <= pwm + 3'd1;
            end
            if (snap_stb) begin
                bright_snap <= bright;
            end
        end
    end

    assign pwm_on = (pwm <= bright_snap);
`else
    logic pwm_on;

    assign pwm_on = 1'b1;
`endif

    always_comb begin
        lit     = enable && !in_blank && pwm_on;
        an_nxt  = OFF;
        seg_nxt = OFF;
        if (lit) begin
            an_nxt  = (seg_vec_t'(1) << idx) ^ OFF;
            seg_nxt = snap[idx] ^ OFF;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_o   <= OFF;
            an_o    <= OFF;
            frame_o <= 1'b0;
        end else begin
            seg_o   <= seg_nxt;
            an_o    <= an_nxt;
            frame_o <= enable && frame_end;
        end
    end

endmodule
